// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, functs, FSM states, ALU ops.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                             (fn == FN_OR)  || (fn == FN_SLT);
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/mips_multicycle_core_if.sv
// Instruction and data memory req/ack buses of the core; master = core, slave = memories.
interface mips_multicycle_core_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic              dmem_ack;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mips_regfile.sv
// 32 x XLEN register file: two async read ports, one sync write port, r0 reads as zero.
module mips_regfile #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr_a,
    input  logic [4:0]      i_raddr_b,
    output logic [XLEN-1:0] o_rdata_a,
    output logic [XLEN-1:0] o_rdata_b
);
    logic [XLEN-1:0] r_regs [0:31];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == 5'd0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 5'd0) ? '0 : r_regs[i_raddr_b];
endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB FSM around a shared ALU, XLEN-wide datapath.
// Address arithmetic is done in ADDR_W bits, so ADDR_W must not exceed XLEN and must exceed 26.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    mips_multicycle_core_if.master bus,
    output logic                   o_halted,
    output logic                   o_retire
);
    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc, r_target, r_dmem_addr;
    logic [31:0]       r_ir;
    logic [XLEN-1:0]   r_a, r_b, r_aluout, r_mdr, r_dmem_wdata;
    logic              r_imem_req, r_dmem_req, r_dmem_we, r_halted, r_retire;

    logic [5:0]        w_op, w_funct;
    logic [4:0]        w_rs, w_rt, w_rd;
    logic [XLEN-1:0]   w_imm_x, w_rf_a, w_rf_b, w_alu_b, w_alu_y;
    logic [ADDR_W-1:0] w_imm_a, w_ls_addr;
    alu_op_e           w_alu_op;

    assign w_op      = r_ir[31:26];
    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_funct   = r_ir[5:0];
    assign w_imm_x   = {{(XLEN-16){r_ir[15]}}, r_ir[15:0]};
    assign w_imm_a   = {{(ADDR_W-16){r_ir[15]}}, r_ir[15:0]};
    assign w_ls_addr = r_a[ADDR_W-1:0] + w_imm_a;

    mips_regfile #(.XLEN(XLEN)) u_regfile (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_we     (r_state == S_WB),
        .i_waddr  ((w_op == OP_RTYPE) ? w_rd : w_rt),
        .i_wdata  ((w_op == OP_LW) ? r_mdr : r_aluout),
        .i_raddr_a(w_rs),
        .i_raddr_b(w_rt),
        .o_rdata_a(w_rf_a),
        .o_rdata_b(w_rf_b)
    );

    always_comb begin
        w_alu_op = ALU_ADD;
        if (w_op == OP_RTYPE) begin
            case (w_funct)
                FN_SUB:  w_alu_op = ALU_SUB;
                FN_AND:  w_alu_op = ALU_AND;
                FN_OR:   w_alu_op = ALU_OR;
                FN_SLT:  w_alu_op = ALU_SLT;
                default: w_alu_op = ALU_ADD;
            endcase
        end
    end

    assign w_alu_b = (w_op == OP_RTYPE) ? r_b : w_imm_x;

    always_comb begin
        w_alu_y = '0;
        case (w_alu_op)
            ALU_ADD: w_alu_y = r_a + w_alu_b;
            ALU_SUB: w_alu_y = r_a - w_alu_b;
            ALU_AND: w_alu_y = r_a & w_alu_b;
            ALU_OR:  w_alu_y = r_a | w_alu_b;
            ALU_SLT: w_alu_y = {{(XLEN-1){1'b0}}, $signed(r_a) < $signed(w_alu_b)};
            default: w_alu_y = '0;
        endcase
    end

    // Every path back to FETCH raises imem_req and pulses retire on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_target     <= '0;
            r_ir         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_aluout     <= '0;
            r_mdr        <= '0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_halted     <= 1'b0;
            r_retire     <= 1'b0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (bus.imem_ack) begin
                        r_ir       <= bus.imem_rdata;
                        r_pc       <= r_pc + ADDR_W'(1);
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a      <= w_rf_a;
                    r_b      <= w_rf_b;
                    r_target <= r_pc + w_imm_a;
                    if (is_legal(w_op, w_funct)) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (w_op)
                        OP_LW, OP_SW: begin
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= (w_op == OP_SW);
                            r_dmem_addr  <= w_ls_addr;
                            r_dmem_wdata <= r_b;
                            r_state      <= S_MEM;
                        end
                        OP_BEQ, OP_BNE, OP_J: begin
                            if (w_op == OP_J)
                                r_pc <= {r_pc[ADDR_W-1:26], r_ir[25:0]};
                            else if ((r_a == r_b) == (w_op == OP_BEQ))
                                r_pc <= r_target;
                            r_state    <= S_FETCH;
                            r_imem_req <= 1'b1;
                            r_retire   <= 1'b1;
                        end
                        default: begin
                            r_aluout <= w_alu_y;
                            r_state  <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        if (r_dmem_we) begin
                            r_state    <= S_FETCH;
                            r_imem_req <= 1'b1;
                            r_retire   <= 1'b1;
                        end else begin
                            r_mdr   <= bus.dmem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                    r_retire   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_req   = r_imem_req;
    assign bus.imem_addr  = r_pc;
    assign bus.dmem_req   = r_dmem_req;
    assign bus.dmem_we    = r_dmem_we;
    assign bus.dmem_addr  = r_dmem_addr;
    assign bus.dmem_wdata = r_dmem_wdata;
    assign o_halted       = r_halted;
    assign o_retire       = r_retire;
endmodule
